// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle controller and the RV32 datapath plus unified memory.
// master = controller side, slave = datapath/memory side.
interface multicycle_controller_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             mem_read;
  logic             mem_write;
  logic             i_or_d;
  logic             ir_write;
  logic             pc_en;
  logic             pc_source;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic             mem_to_reg;
  logic             reg_write;
  logic             instr_done;
  logic             halted;
  logic [CNT_W-1:0] retired_count;

  modport master (
    input  opcode, zero, mem_ready,
    output mem_read, mem_write, i_or_d, ir_write, pc_en, pc_source,
           alu_src_a, alu_src_b, alu_op, mem_to_reg, reg_write,
           instr_done, halted, retired_count
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  mem_read, mem_write, i_or_d, ir_write, pc_en, pc_source,
           alu_src_a, alu_src_b, alu_op, mem_to_reg, reg_write,
           instr_done, halted, retired_count
  );
endinterface

// File: rtl/multicycle_controller.sv
// Per-state control FSM for a shared-memory multi-cycle RV32 datapath (LW, SW, BEQ, R-type)
// with a ready-handshaked memory port and a retired-instruction counter.
module multicycle_controller #(
  parameter int CNT_W           = 32,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_ALU_WB   = 4'd7,
    S_BRANCH   = 4'd8,
    S_HALT     = 4'd9
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_REGA  = 2'b10;
  localparam logic [1:0] SRC_B_REGB  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR  = 2'b01;
  localparam logic [1:0] SRC_B_IMM   = 2'b10;
  localparam logic [1:0] ALU_ADD     = 2'b00;
  localparam logic [1:0] ALU_SUB     = 2'b01;
  localparam logic [1:0] ALU_FUNCT   = 2'b10;

  state_t           state_r;
  state_t           next_state_s;
  logic [CNT_W-1:0] retired_count_r;

  logic       mem_read_s;
  logic       mem_write_s;
  logic       i_or_d_s;
  logic       ir_write_s;
  logic       pc_en_s;
  logic       pc_source_s;
  logic [1:0] alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic [1:0] alu_op_s;
  logic       mem_to_reg_s;
  logic       reg_write_s;
  logic       instr_done_s;
  logic       halted_s;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and per-state control decode; every output defaults to 0
  always_comb begin
    next_state_s = state_r;
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    i_or_d_s     = 1'b0;
    ir_write_s   = 1'b0;
    pc_en_s      = 1'b0;
    pc_source_s  = 1'b0;
    alu_src_a_s  = SRC_A_PC;
    alu_src_b_s  = SRC_B_REGB;
    alu_op_s     = ALU_ADD;
    mem_to_reg_s = 1'b0;
    reg_write_s  = 1'b0;
    instr_done_s = 1'b0;
    halted_s     = 1'b0;

    case (state_r)
      S_FETCH: begin
        // PC+4 is computed every fetch cycle but only committed with the IR load
        mem_read_s  = 1'b1;
        alu_src_a_s = SRC_A_PC;
        alu_src_b_s = SRC_B_FOUR;
        alu_op_s    = ALU_ADD;
        ir_write_s  = bus.mem_ready;
        pc_en_s     = bus.mem_ready;
        if (bus.mem_ready) begin
          next_state_s = S_DECODE;
        end else begin
          next_state_s = S_FETCH;
        end
      end

      S_DECODE: begin
        // Branch target old_pc+imm is precomputed into ALUOut here
        alu_src_a_s = SRC_A_OLDPC;
        alu_src_b_s = SRC_B_IMM;
        alu_op_s    = ALU_ADD;
        case (bus.opcode)
          OP_LW, OP_SW: next_state_s = S_MEM_ADDR;
          OP_R:         next_state_s = S_EXEC;
          OP_BEQ:       next_state_s = S_BRANCH;
          default: begin
            if (TRAP_ON_ILLEGAL) begin
              next_state_s = S_HALT;
            end else begin
              next_state_s = S_FETCH;
              instr_done_s = 1'b1;
            end
          end
        endcase
      end

      S_MEM_ADDR: begin
        alu_src_a_s = SRC_A_REGA;
        alu_src_b_s = SRC_B_IMM;
        alu_op_s    = ALU_ADD;
        case (bus.opcode)
          OP_LW: next_state_s = S_MEM_RD;
          OP_SW: next_state_s = S_MEM_WR;
          default: begin
            if (TRAP_ON_ILLEGAL) begin
              next_state_s = S_HALT;
            end else begin
              next_state_s = S_FETCH;
            end
          end
        endcase
      end

      S_MEM_RD: begin
        mem_read_s = 1'b1;
        i_or_d_s   = 1'b1;
        if (bus.mem_ready) begin
          next_state_s = S_MEM_WB;
        end else begin
          next_state_s = S_MEM_RD;
        end
      end

      S_MEM_WB: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = 1'b1;
        instr_done_s = 1'b1;
        next_state_s = S_FETCH;
      end

      S_MEM_WR: begin
        mem_write_s  = 1'b1;
        i_or_d_s     = 1'b1;
        instr_done_s = bus.mem_ready;
        if (bus.mem_ready) begin
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_MEM_WR;
        end
      end

      S_EXEC: begin
        alu_src_a_s  = SRC_A_REGA;
        alu_src_b_s  = SRC_B_REGB;
        alu_op_s     = ALU_FUNCT;
        next_state_s = S_ALU_WB;
      end

      S_ALU_WB: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = 1'b0;
        instr_done_s = 1'b1;
        next_state_s = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a_s  = SRC_A_REGA;
        alu_src_b_s  = SRC_B_REGB;
        alu_op_s     = ALU_SUB;
        pc_source_s  = 1'b1;
        pc_en_s      = bus.zero;
        instr_done_s = 1'b1;
        next_state_s = S_FETCH;
      end

      S_HALT: begin
        halted_s     = 1'b1;
        next_state_s = S_HALT;
      end

      default: begin
        // Unused encodings (10..15) are treated as a fault and parked in HALT
        next_state_s = S_HALT;
      end
    endcase
  end

  // Retired-instruction counter; wraps naturally at 2^CNT_W
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_count_r <= {CNT_W{1'b0}};
    end else if (instr_done_s) begin
      retired_count_r <= retired_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      retired_count_r <= retired_count_r;
    end
  end

  // While rst is high the state is already FETCH, but its Mealy/Moore
  // request must not reach memory, so every control output is masked.
  assign bus.mem_read      = mem_read_s   & ~rst;
  assign bus.mem_write     = mem_write_s  & ~rst;
  assign bus.i_or_d        = i_or_d_s     & ~rst;
  assign bus.ir_write      = ir_write_s   & ~rst;
  assign bus.pc_en         = pc_en_s      & ~rst;
  assign bus.pc_source     = pc_source_s  & ~rst;
  assign bus.alu_src_a     = alu_src_a_s  & {2{~rst}};
  assign bus.alu_src_b     = alu_src_b_s  & {2{~rst}};
  assign bus.alu_op        = alu_op_s     & {2{~rst}};
  assign bus.mem_to_reg    = mem_to_reg_s & ~rst;
  assign bus.reg_write     = reg_write_s  & ~rst;
  assign bus.instr_done    = instr_done_s & ~rst;
  assign bus.halted        = halted_s     & ~rst;
  assign bus.retired_count = retired_count_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench: a per-instruction cycle-expectation model builds the
// expected control word for every cycle and the retired count is tracked independently.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic [1:0] rst_s;
  always #5 clk = ~clk;

  multicycle_controller_if #(.CNT_W(32)) if0 ();
  multicycle_controller_if #(.CNT_W(4))  if1 ();

  multicycle_controller #(.CNT_W(32), .TRAP_ON_ILLEGAL(1'b1)) dut0 (
    .clk(clk), .rst(rst_s[0]), .bus(if0.master)
  );
  multicycle_controller #(.CNT_W(4), .TRAP_ON_ILLEGAL(1'b0)) dut1 (
    .clk(clk), .rst(rst_s[1]), .bus(if1.master)
  );

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_ILL = 7'b0010011;

  typedef struct {
    logic [15:0] exp;
    logic        rdy;
    logic        z;
    logic [6:0]  op;
  } item_t;

  item_t       q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_cnt[2];
  bit          pending_release[2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // {mem_read,mem_write,i_or_d,ir_write,pc_en,pc_source,src_a,src_b,alu_op,mem_to_reg,reg_write,instr_done,halted}
  function automatic logic [15:0] ctl(input bit mr, input bit mw, input bit iod, input bit irw,
                                      input bit pce, input bit pcs, input logic [1:0] sa,
                                      input logic [1:0] sb, input logic [1:0] ao, input bit m2r,
                                      input bit rw, input bit done, input bit hlt);
    return {mr, mw, iod, irw, pce, pcs, sa, sb, ao, m2r, rw, done, hlt};
  endfunction

  function automatic logic [15:0] get_obs(input int d);
    if (d == 0)
      return {if0.mem_read, if0.mem_write, if0.i_or_d, if0.ir_write, if0.pc_en, if0.pc_source,
              if0.alu_src_a, if0.alu_src_b, if0.alu_op, if0.mem_to_reg, if0.reg_write,
              if0.instr_done, if0.halted};
    else
      return {if1.mem_read, if1.mem_write, if1.i_or_d, if1.ir_write, if1.pc_en, if1.pc_source,
              if1.alu_src_a, if1.alu_src_b, if1.alu_op, if1.mem_to_reg, if1.reg_write,
              if1.instr_done, if1.halted};
  endfunction

  function automatic logic [31:0] get_cnt(input int d);
    if (d == 0) return if0.retired_count;
    else        return {28'd0, if1.retired_count};
  endfunction

  task automatic drive(input int d, input logic [6:0] op, input logic z, input logic rdy);
    if (d == 0) begin
      if0.opcode = op; if0.zero = z; if0.mem_ready = rdy;
    end else begin
      if1.opcode = op; if1.zero = z; if1.mem_ready = rdy;
    end
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [6:0] rop();
    return 7'($urandom);
  endfunction

  task automatic push(input logic [15:0] e, input logic rdy, input logic z, input logic [6:0] op);
    item_t it;
    it.exp = e; it.rdy = rdy; it.z = z; it.op = op;
    q.push_back(it);
  endtask

  // Expected cycle sequence of one instruction; wf/wm = memory wait cycles in fetch / data access
  task automatic build(input logic [6:0] op, input logic z, input int wf, input int wm, input bit trap);
    bit legal;
    legal = (op == OP_LW) || (op == OP_SW) || (op == OP_R) || (op == OP_BEQ);
    for (int i = 0; i < wf; i++)
      push(ctl(1,0,0,0,0,0,2'b00,2'b01,2'b00,0,0,0,0), 1'b0, rb(), rop());
    push(ctl(1,0,0,1,1,0,2'b00,2'b01,2'b00,0,0,0,0), 1'b1, rb(), rop());
    push(ctl(0,0,0,0,0,0,2'b01,2'b10,2'b00,0,0,!legal && !trap,0), rb(), rb(), op);
    if (op == OP_LW || op == OP_SW)
      push(ctl(0,0,0,0,0,0,2'b10,2'b10,2'b00,0,0,0,0), rb(), rb(), op);
    if (op == OP_LW) begin
      for (int i = 0; i < wm; i++)
        push(ctl(1,0,1,0,0,0,2'b00,2'b00,2'b00,0,0,0,0), 1'b0, rb(), op);
      push(ctl(1,0,1,0,0,0,2'b00,2'b00,2'b00,0,0,0,0), 1'b1, rb(), op);
      push(ctl(0,0,0,0,0,0,2'b00,2'b00,2'b00,1,1,1,0), rb(), rb(), op);
    end else if (op == OP_SW) begin
      for (int i = 0; i < wm; i++)
        push(ctl(0,1,1,0,0,0,2'b00,2'b00,2'b00,0,0,0,0), 1'b0, rb(), op);
      push(ctl(0,1,1,0,0,0,2'b00,2'b00,2'b00,0,0,1,0), 1'b1, rb(), op);
    end else if (op == OP_R) begin
      push(ctl(0,0,0,0,0,0,2'b10,2'b00,2'b10,0,0,0,0), rb(), rb(), op);
      push(ctl(0,0,0,0,0,0,2'b00,2'b00,2'b00,0,1,1,0), rb(), rb(), op);
    end else if (op == OP_BEQ) begin
      push(ctl(0,0,0,0,z,1,2'b10,2'b00,2'b01,0,0,1,0), rb(), z, op);
    end else if (trap) begin
      for (int i = 0; i < 6; i++)
        push(ctl(0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,0,1), rb(), rb(), rop());
    end
  endtask

  // Play up to n queued cycles on DUT d, checking control word and retired count each cycle
  task automatic exec(input int d, input int n, input string tag);
    item_t it;
    logic [31:0] mask;
    mask = (d == 0) ? 32'hFFFF_FFFF : 32'h0000_000F;
    for (int k = 0; k < n && q.size() > 0; k++) begin
      it = q.pop_front();
      @(negedge clk);
      if (pending_release[d]) begin
        rst_s[d] = 1'b0;
        pending_release[d] = 1'b0;
      end
      drive(d, it.op, it.z, it.rdy);
      #1;
      check_eq({tag, " ctl"}, {16'd0, get_obs(d)}, {16'd0, it.exp});
      check_eq({tag, " cnt"}, get_cnt(d), exp_cnt[d]);
      if (it.exp[1]) exp_cnt[d] = (exp_cnt[d] + 32'd1) & mask;
    end
  endtask

  // One cycle with rst high: every control output must be 0 and the counter cleared
  task automatic reset_cycle(input int d, input string tag);
    @(negedge clk);
    rst_s[d] = 1'b1;
    drive(d, rop(), rb(), rb());
    #1;
    exp_cnt[d] = 32'd0;
    check_eq({tag, " rst ctl"}, {16'd0, get_obs(d)}, 32'd0);
    check_eq({tag, " rst cnt"}, get_cnt(d), 32'd0);
  endtask

  function automatic logic [6:0] pick_op(input bit allow_ill);
    int r;
    r = allow_ill ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 3));
    case (r)
      0:       return OP_LW;
      1:       return OP_SW;
      2:       return OP_R;
      3:       return OP_BEQ;
      default: return OP_ILL;
    endcase
  endfunction

  initial begin
    rst_s = 2'b11;
    exp_cnt[0] = 32'd0;
    exp_cnt[1] = 32'd0;
    pending_release[0] = 1'b0;
    pending_release[1] = 1'b0;
    drive(0, OP_LW, 1'b0, 1'b1);
    drive(1, OP_LW, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      reset_cycle(0, "dut0");
      reset_cycle(1, "dut1");
    end

    // Directed: LW, SW with 3 write stalls, BEQ taken / not taken, 3x R-type
    pending_release[0] = 1'b1;
    build(OP_LW, 1'b0, 0, 0, 1'b1);   exec(0, 100, "lw");
    build(OP_SW, 1'b0, 0, 3, 1'b1);   exec(0, 100, "sw_stall");
    build(OP_BEQ, 1'b1, 0, 0, 1'b1);  exec(0, 100, "beq_taken");
    build(OP_BEQ, 1'b0, 0, 0, 1'b1);  exec(0, 100, "beq_not");
    for (int i = 0; i < 3; i++) begin
      build(OP_R, 1'b0, 0, 0, 1'b1);  exec(0, 100, "rtype");
    end

    // Random legal traffic with random fetch/data stalls
    for (int i = 0; i < 40; i++) begin
      build(pick_op(1'b0), rb(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1);
      exec(0, 100, "rand0");
    end

    // Reset during a stalled LW read: FETCH + DECODE + MEM_ADDR + 2 stalled MEM_RD cycles
    build(OP_LW, 1'b0, 0, 4, 1'b1);
    exec(0, 5, "lw_abort");
    q.delete();
    reset_cycle(0, "mid");
    reset_cycle(0, "mid");
    pending_release[0] = 1'b1;
    build(OP_R, 1'b0, 0, 0, 1'b1);    exec(0, 100, "after_rst");

    // Illegal opcode traps into sticky HALT, then only reset recovers
    build(OP_ILL, 1'b0, int'($urandom_range(0, 2)), 0, 1'b1);
    exec(0, 100, "halt");
    reset_cycle(0, "halt");
    pending_release[0] = 1'b1;
    build(OP_BEQ, 1'b1, 1, 0, 1'b1);  exec(0, 100, "post_halt");

    // 4-bit counter, illegal opcodes skipped: 17 instructions wrap the count to 1
    pending_release[1] = 1'b1;
    build(OP_ILL, 1'b0, 0, 0, 1'b0);  exec(1, 100, "skip_ill");
    for (int i = 0; i < 16; i++) begin
      build(pick_op(1'b1), rb(), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0);
      exec(1, 100, "wrap");
    end
    @(negedge clk);
    drive(1, rop(), rb(), 1'b0);
    #1;
    check_eq("wrap final", get_cnt(1), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore/Mealy FSM that sequences a shared-memory, multi-cycle RV32 datapath for LW, SW, BEQ and R-type instructions.
- Replaces the single-cycle opcode decoder with per-state control.
- Issues memory requests with a ready handshake, gates PC/IR updates, and counts retired instructions.
- Sits between instruction register opcode field, ALU zero flag, unified memory, and datapath muxes/enables.

Parameters:
- CNT_W, 32, width of retired-instruction counter.
- TRAP_ON_ILLEGAL, 1, 1 = illegal opcode enters sticky HALT; 0 = illegal opcode is skipped (return to FETCH).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous active-high reset.
- opcode  in  7  instr[6:0] from instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory accepted/completed current request this cycle.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- i_or_d  out  1  memory address select: 0=PC, 1=ALUOut.
- ir_write  out  1  load instruction register and old_pc.
- pc_en  out  1  PC register enable.
- pc_source  out  1  PC next select: 0=ALU result, 1=ALUOut.
- alu_src_a  out  2  00=PC, 01=old_pc, 10=reg A.
- alu_src_b  out  2  00=reg B, 01=const 4, 10=immediate.
- alu_op  out  2  00=add, 01=subtract, 10=funct-decoded.
- mem_to_reg  out  1  writeback select: 0=ALUOut, 1=memory data register.
- reg_write  out  1  register file write enable.
- instr_done  out  1  one-cycle pulse on final cycle of each instruction.
- halted  out  1  FSM in HALT.
- retired_count  out  CNT_W  instructions completed.

Behaviour:
- Reset (async, rst=1): state=FETCH, retired_count=0. All outputs forced to 0 while rst is high, including FETCH's mem_read. First FETCH request appears in the first cycle after rst deasserts.
- Output rule: unlisted outputs are 0 in every state.
- States (4-bit): FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC=6, ALU_WB=7, BRANCH=8, HALT=9.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=00, alu_src_b=01, alu_op=00, pc_source=0.
  - ir_write=pc_en=mem_ready (Mealy).
  - mem_ready=1 -> DECODE; else stay, with no PC/IR update.
- DECODE:
  - Outputs: alu_src_a=01, alu_src_b=10, alu_op=00 (branch target into ALUOut).
  - Opcode 0000011 or 0100011 -> MEM_ADDR; 0110011 -> EXEC; 1100011 -> BRANCH.
  - Other opcodes: HALT if TRAP_ON_ILLEGAL, else FETCH with instr_done=1.
- MEM_ADDR:
  - Outputs: alu_src_a=10, alu_src_b=10, alu_op=00.
  - Next state: LW -> MEM_RD, SW -> MEM_WR. Opcode is stable because IR is not written.
- MEM_RD: mem_read=1, i_or_d=1; wait mem_ready -> MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, instr_done=1 -> FETCH.
- MEM_WR: mem_write=1, i_or_d=1; instr_done=mem_ready; mem_ready -> FETCH, else stay.
- EXEC: alu_src_a=10, alu_src_b=00, alu_op=10 -> ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0, instr_done=1 -> FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, alu_op=01, pc_source=1, pc_en=zero, instr_done=1 -> FETCH.
- HALT: halted=1, all other outputs 0; exits only on reset.
- Handshake:
  - Request held stable (mem_read/mem_write, i_or_d) every cycle until mem_ready=1.
  - mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
  - mem_ready already high on the first request cycle completes in that cycle.
- Latency with mem_ready tied 1: LW 5, SW 4, R-type 4, BEQ 3 cycles. Each wait cycle adds 1.
- retired_count: +1 on each clk edge where instr_done=1; wraps from 2^CNT_W-1 to 0; no saturation.
- Reset mid-instruction (including during a stalled memory request): immediate return to FETCH with outputs 0. No partial write enable survives past rst assertion.
- mem_write and reg_write are never asserted in the same cycle. mem_read and mem_write are never both 1.

Test Plan:
- LW, mem_ready=1: state trace 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in cycle 5; retired_count 0->1.
- SW with mem_ready low for 3 cycles in MEM_WR: mem_write held 4 cycles, i_or_d=1 throughout; instr_done on 4th MEM_WR cycle only; total 7 cycles.
- BEQ, zero=1 then zero=0: pc_en=1 with pc_source=1 in BRANCH for the taken case; pc_en=0 for not-taken; both take 3 cycles.
- R-type back-to-back x3, mem_ready=1: 12 cycles; retired_count=3; alu_op=10 in EXEC only.
- Opcode 0010011, TRAP_ON_ILLEGAL=1: halted=1 from cycle 3, outputs 0, stuck until rst. With TRAP_ON_ILLEGAL=0: returns to FETCH, retired_count +1.
- rst pulsed during MEM_RD stall: outputs 0 immediately; FETCH mem_read=1 the cycle after release. CNT_W=4 run of 17 instructions -> retired_count=1.
